// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output block driven directly from the SPI register bank.
// Optional duty shadow register (loaded at period start) enabled by PWM_SHADOW_DUTY_EN.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PRE_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OUT_W = 16;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PRE_W-1:0] prescaler;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_eff;
    logic [OUT_W-1:0] en_out;
    logic [OUT_W-1:0] en_pwm;
    logic [OUT_W-1:0] out_next;
    logic             pre_wrap;
    logic             period_wrap;
    logic             pwm_sig;

    assign en_out      = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign pre_wrap    = (prescaler == PRE_MAX);
    assign period_wrap = pre_wrap && (pwm_cnt == CNT_MAX);

    // Prescaler and PWM step counter; both restart at 0/0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (pre_wrap) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + CNT_W'(1);
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

`ifdef PWM_SHADOW_DUTY_EN
    logic [CNT_W-1:0] duty_shadow;

    // Duty is only picked up at the 0/0 boundary so a period never mixes two duties.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow <= '0;
        end else if (period_wrap) begin
            duty_shadow <= pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_shadow;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // 0xFF is forced high so the output does not drop during the cnt==255 step.
    always_comb begin
        pwm_sig  = 1'b0;
        out_next = '0;
        pwm_sig  = (duty_eff == CNT_MAX) || (pwm_cnt < duty_eff);
        out_next = en_out & (~en_pwm | {OUT_W{pwm_sig}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= out_next;
            period_start <= period_wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: arithmetic time-based reference model plus
// directed duty/extreme/static/reset/shadow scenarios and randomized register traffic.
module tb_pwm_peripheral;

    localparam int unsigned D = 13;
    localparam int unsigned P = D * 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    int checks   = 0;
    int failures = 0;

    pwm_peripheral #(.CLK_DIV(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // Reference: position in the period is simply clk edges since reset modulo P.
    int unsigned n = 0;
    logic [15:0] m_out = '0;
    logic        m_ps = 1'b0;
    logic [7:0]  m_shadow = '0;

    function automatic logic [15:0] ref_out(int unsigned pos, logic [7:0] eff,
                                            logic [15:0] eo, logic [15:0] ep);
        int unsigned step;
        bit sig;
        logic [15:0] r;
        step = (pos / D) % 256;
        sig  = (eff == 8'hFF) || (step < int'(eff));
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])     r[i] = 1'b0;
            else if (!ep[i]) r[i] = 1'b1;
            else            r[i] = sig;
        end
        return r;
    endfunction

    function automatic logic [7:0] eff_duty(logic [7:0] shadow, logic [7:0] live);
`ifdef PWM_SHADOW_DUTY_EN
        return shadow;
`else
        return live;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n        <= 0;
            m_out    <= '0;
            m_ps     <= 1'b0;
            m_shadow <= '0;
        end else begin
            m_out <= ref_out(n, eff_duty(m_shadow, pwm_duty_cycle),
                             {en_reg_out_15_8, en_reg_out_7_0},
                             {en_reg_pwm_15_8, en_reg_pwm_7_0});
            m_ps  <= (n == P - 1);
            if (n == P - 1) m_shadow <= pwm_duty_cycle;
            n <= (n + 1) % P;
        end
    end

    task automatic check_cycle();
        @(negedge clk);
        checks++;
        assert (out === m_out) else begin
            failures++;
            $error("FAIL model_out observed=%h expected=%h pos=%0d", out, m_out, n);
        end
        checks++;
        assert (period_start === m_ps) else begin
            failures++;
            $error("FAIL model_ps observed=%b expected=%b pos=%0d", period_start, m_ps, n);
        end
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) check_cycle();
    endtask

    task automatic wait_ps(int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            check_cycle();
            if (period_start === 1'b1) seen = 1;
        end
        checks++;
        assert (seen) else begin
            failures++;
            $error("FAIL wait_ps observed=timeout expected=pulse within %0d", bound);
        end
    endtask

    // Counts out[0] high over one period starting at the current (period_start) cycle.
    task automatic measure(int write_at, logic [7:0] write_val, output int high);
        high = int'(out[0]);
        if (write_at == 0) pwm_duty_cycle = write_val;
        for (int i = 1; i < int'(P); i++) begin
            check_cycle();
            high += int'(out[0]);
            if (i == write_at) pwm_duty_cycle = write_val;
        end
    endtask

    task automatic expect_int(string tag, int observed, int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic set_en(logic [15:0] eo, logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    int high;
    int cnt;
    int exp_cur;

    initial begin
        rst = 1'b1;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h00;
        repeat (3) @(negedge clk);
        expect_int("reset_out", int'(out), 0);
        expect_int("reset_ps", int'(period_start), 0);
        rst = 1'b0;

        // Duty 0x80 half/half
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        wait_ps(P + 10);
        wait_ps(P + 10);
        measure(-1, 8'h00, high);
        expect_int("duty80_high", high, 1664);
        check_cycle();
        expect_int("duty80_period", int'(period_start), 1);

        // Extremes: 0x00 and 0xFF over three periods each
        pwm_duty_cycle = 8'h00;
        wait_ps(P + 10);
        wait_ps(P + 10);
        for (int k = 0; k < 3; k++) begin
            measure(-1, 8'h00, high);
            expect_int("duty00_high", high, 0);
            if (k < 2) wait_ps(2);
        end
        pwm_duty_cycle = 8'hFF;
        wait_ps(P + 10);
        wait_ps(P + 10);
        for (int k = 0; k < 3; k++) begin
            measure(-1, 8'h00, high);
            expect_int("dutyFF_high", high, int'(P));
            if (k < 2) wait_ps(2);
        end

        // Static modes
        set_en(16'hFFFF, 16'h0000);
        check_cycle();
        expect_int("static_all_on", int'(out), 32'hFFFF);
        set_en(16'h00F0, 16'hFFFF);
        check_cycle();
        expect_int("enable_dominates", int'(out), 32'h00F0);

        // Mid-period reset at pwm_cnt=100
        set_en(16'hFFFF, 16'h0000);
        cnt = 0;
        while (n != 100 * D && cnt < int'(P) + 10) begin
            check_cycle();
            cnt++;
        end
        expect_int("reach_cnt100", int'(n), 100 * int'(D));
        rst = 1'b1;
        check_cycle();
        expect_int("midreset_out", int'(out), 0);
        rst = 1'b0;
        cnt = 0;
        do begin
            check_cycle();
            cnt++;
        end while (period_start !== 1'b1 && cnt < int'(P) + 10);
        expect_int("midreset_ps_delay", cnt, int'(P));

        // Mid-period duty change 0x40 -> 0xC0 at pwm_cnt=0x50
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h40;
        wait_ps(P + 10);
        wait_ps(P + 10);
        measure(8'h50 * D, 8'hC0, high);
`ifdef PWM_SHADOW_DUTY_EN
        exp_cur = 832;
`else
        exp_cur = 2288;
`endif
        expect_int("dutychg_current", high, exp_cur);
        wait_ps(2);
        measure(-1, 8'h00, high);
        expect_int("dutychg_next", high, 2496);

        // Randomized register traffic against the model
        for (int k = 0; k < 24; k++) begin
            set_en(16'($urandom), 16'($urandom));
            pwm_duty_cycle = (k % 6 == 0) ? 8'hFF : (k % 6 == 1) ? 8'h00 : 8'($urandom);
            run(int'($urandom_range(1, 700)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
